// File: rtl/rsa_modexp_if.sv
// ============================================================================
// Module   : rsa_modexp_if
// Purpose  : Operand/result handshake bundle for the rsa_modexp engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rsa_modexp_if #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     base_i;
    logic [EXP_WIDTH-1:0] exp_i;
    logic [WIDTH-1:0]     mod_i;
    logic [WIDTH-1:0]     out_data_o;
    logic                 out_err_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 busy_o;

    modport slave (
        input  in_valid_i, base_i, exp_i, mod_i, out_ready_i,
        output in_ready_o, out_data_o, out_err_o, out_valid_o, busy_o
    );

    modport master (
        output in_valid_i, base_i, exp_i, mod_i, out_ready_i,
        input  in_ready_o, out_data_o, out_err_o, out_valid_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/rsa_modexp.sv
// ============================================================================
// Module   : rsa_modexp
// Purpose  : Left-to-right square-and-multiply B^E mod M with a bit-serial
//            modular multiplier. Optional macro RSA_MODEXP_SKIP_LEADING_ZEROS_EN
//            starts at the highest set exponent bit instead of the MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_modexp #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     stall,
    rsa_modexp_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SQR   = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state, r_next;
    logic [WIDTH-1:0]     r_base, r_mod, r_acc, r_p, r_data;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [IW-1:0]        r_bit;
    logic [CW-1:0]        r_cnt;
    logic                 r_err;

    logic                 w_in_ready, w_accept, w_op_last, w_bad, w_exp_bit, w_xbit;
    logic [WIDTH-1:0]     w_y, w_prod;
    logic [WIDTH+1:0]     w_sum, w_s1, w_mod_ext;

    // rst gates in_ready so nothing is offered while reset is asserted
    assign w_in_ready = (r_state == S_IDLE) && !stall && rst;
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_op_last  = (r_cnt == '0);
    assign w_bad      = (r_mod < WIDTH'(2)) || (r_base >= r_mod);
    assign w_exp_bit  = r_exp[r_bit];

`ifdef RSA_MODEXP_SKIP_LEADING_ZEROS_EN
    logic [IW-1:0] w_top;
    logic          w_exp_zero;
    always_comb begin
        w_top = '0;
        for (int i = 0; i < EXP_WIDTH; i++) begin
            if (r_exp[i]) w_top = IW'(i);
        end
    end
    assign w_exp_zero = (r_exp == '0);
`endif

    // P stays below M, so 2P + Y < 3M and two conditional subtractions suffice
    assign w_y       = (r_state == S_MUL) ? r_base : r_acc;
    assign w_xbit    = r_acc[r_cnt];
    assign w_mod_ext = {2'b00, r_mod};
    assign w_sum     = {1'b0, r_p, 1'b0} + (w_xbit ? {2'b00, w_y} : '0);
    assign w_s1      = (w_sum >= w_mod_ext) ? (w_sum - w_mod_ext) : w_sum;
    assign w_prod    = (w_s1 >= w_mod_ext) ? WIDTH'(w_s1 - w_mod_ext) : WIDTH'(w_s1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_state <= S_IDLE;
        else if (!stall) r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) r_next = S_CHECK;
            S_CHECK: begin
                if (w_bad) r_next = S_DONE;
`ifdef RSA_MODEXP_SKIP_LEADING_ZEROS_EN
                else if (w_exp_zero) r_next = S_DONE;
`endif
                else r_next = S_SQR;
            end
            S_SQR: if (w_op_last) begin
                if (w_exp_bit)        r_next = S_MUL;
                else if (r_bit == '0) r_next = S_DONE;
            end
            S_MUL: if (w_op_last) r_next = (r_bit == '0) ? S_DONE : S_SQR;
            S_DONE:  if (bus.out_ready_i) r_next = S_IDLE;
            default: r_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base <= '0; r_mod <= '0; r_exp <= '0; r_acc <= '0; r_p <= '0;
            r_data <= '0; r_err <= 1'b0; r_bit <= '0; r_cnt <= '0;
        end else if (!stall) begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_base <= bus.base_i;
                    r_exp  <= bus.exp_i;
                    r_mod  <= bus.mod_i;
                end
                S_CHECK: begin
                    r_acc <= WIDTH'(1);
                    r_p   <= '0;
                    r_cnt <= CW'(WIDTH-1);
                    if (w_bad) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else begin
`ifdef RSA_MODEXP_SKIP_LEADING_ZEROS_EN
                        r_bit <= w_top;
                        if (w_exp_zero) begin
                            r_data <= WIDTH'(1);
                            r_err  <= 1'b0;
                        end
`else
                        r_bit <= IW'(EXP_WIDTH-1);
`endif
                    end
                end
                S_SQR, S_MUL: begin
                    if (w_op_last) begin
                        r_acc <= w_prod;
                        r_p   <= '0;
                        r_cnt <= CW'(WIDTH-1);
                        // a set bit still needs its multiply before moving on
                        if (!(r_state == S_SQR && w_exp_bit)) begin
                            if (r_bit == '0) begin
                                r_data <= w_prod;
                                r_err  <= 1'b0;
                            end else begin
                                r_bit <= r_bit - IW'(1);
                            end
                        end
                    end else begin
                        r_p   <= w_prod;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.out_data_o  = r_data;
    assign bus.out_err_o   = r_err;
    assign bus.busy_o      = (r_state != S_IDLE);

endmodule

`default_nettype wire
